regbank16_wr: RTL and testbench

Write side of the 16-entry, 16-bit register bank: accepts single-entry writes over a valid/ready handshake, decodes the 4-bit select to a one-hot enable, and holds the 16 words. It drives the flattened 256-bit bus consumed by the 16:1 read mux (`mux16_1_16b`). A clear request sweeps the bank to zero, one entry per cycle.

---
 rtl/regbank16_wr_pkg.sv | 22 ++
 rtl/regbank16_wr_if.sv | 33 +++
 rtl/regbank16_wr_dec4_16.sv | 21 ++
 rtl/regbank16_wr.sv | 113 +++++++++++
 tb/tb_regbank16_wr.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/regbank16_wr_pkg.sv
// regbank16_wr_pkg
//   Constants and types shared by the register-bank write side and the
//   read-mux side (mux16_1_16b).
//   - wEntries / wData / wSel / wTotal : bank geometry
//   - IDLE / CLEAR                     : write-side FSM encodings
//   - dbg_t                            : FSM observation struct (state + sweep counter)
package regbank16_wr_pkg;

    localparam int wEntries = 16;
    localparam int wData    = 16;
    localparam int wSel     = 4;
    localparam int wTotal   = wEntries * wData;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    typedef struct packed {
        logic [0:0]      state;
        logic [wSel-1:0] cnt;
    } dbg_t;

endpackage

// File: rtl/regbank16_wr_if.sv
// regbank16_wr_if
//   Write channel into the register bank.
//   - wr_valid : initiator has a write pending
//   - wr_ready : bank can take a write this cycle
//   - wr_sel   : target entry index
//   - wr_data  : data to store
//
//   Handshake: a transfer happens on a rising edge where wr_valid and
//   wr_ready are both high. While wr_valid is high and wr_ready is low the
//   initiator keeps wr_valid, wr_sel and wr_data stable. wr_ready may drop
//   combinationally (clear request), so it is not a registered promise.
interface regbank16_wr_if;

    logic                                  wr_valid;
    logic                                  wr_ready;
    logic [regbank16_wr_pkg::wSel-1:0]     wr_sel;
    logic [regbank16_wr_pkg::wData-1:0]    wr_data;

    modport master (
        output wr_valid,
        output wr_sel,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_sel,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/regbank16_wr_dec4_16.sv
// dec4_16
//   4-to-16 one-hot decoder with enable.
//   - en  : when low, all outputs are 0
//   - sel : index of the output to raise
//   - y   : one-hot (or all-zero) result
module dec4_16
    import regbank16_wr_pkg::*;
(
    input  logic                en,
    input  logic [wSel-1:0]     sel,
    output logic [wEntries-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regbank16_wr.sv
// regbank16_wr
//   Write side of the 16 x 16-bit register bank. Accepts one write per
//   cycle over the wr channel, and on clr_req sweeps every entry to zero,
//   one entry per cycle, through the same load path as writes.
//   - clk, rst_n : clock, asynchronous active-low reset
//   - wr         : write channel (slave side)
//   - clr_req    : start a clear sweep (pulse or level, sampled in IDLE)
//   - busy       : clear sweep in progress
//   - Bank       : flattened bank, entry k on Bank[16k+15:16k]
//   - Vld        : per-entry written flag
//   - dbg        : current FSM state and sweep counter
module regbank16_wr
    import regbank16_wr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    regbank16_wr_if.slave       wr,
    input  logic                clr_req,
    output logic                busy,
    output logic [wTotal-1:0]   Bank,
    output logic [wEntries-1:0] Vld,
    output dbg_t                dbg
);

    localparam logic [wSel-1:0] CNT_LAST = wSel'(wEntries - 1);

    logic [0:0]          state;
    logic [wSel-1:0]     cnt;
    logic                sweep;
    logic                accept;
    logic [wEntries-1:0] we_wr;
    logic [wEntries-1:0] we_clr;
    logic [wEntries-1:0] ld;
    logic [wData-1:0]    ld_data;
    logic                ld_vld;

    assign sweep = (state == CLEAR);

    // A clear request takes the cycle: the concurrent write is refused and
    // stays pending on the channel.
    assign wr.wr_ready = !sweep && !clr_req;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign busy        = sweep;

    dec4_16 u_dec_wr (
        .en  (accept),
        .sel (wr.wr_sel),
        .y   (we_wr)
    );

    dec4_16 u_dec_clr (
        .en  (sweep),
        .sel (cnt),
        .y   (we_clr)
    );

    // Writes only happen in IDLE and the sweep only in CLEAR, so the two
    // enable vectors never overlap and the data mux can key off the state.
    assign ld      = we_wr | we_clr;
    assign ld_data = sweep ? '0 : wr.wr_data;
    assign ld_vld  = !sweep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // clr_req is not looked at here: no restart, no extension.
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < wEntries; k++) begin : g_ent
        logic [wData-1:0] q;
        logic             v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
                v <= 1'b0;
            end else if (ld[k]) begin
                q <= ld_data;
                v <= ld_vld;
            end
        end

        assign Bank[k*wData +: wData] = q;
        assign Vld[k]                 = v;
    end

    assign dbg.state = state;
    assign dbg.cnt   = cnt;

endmodule

// File: tb/tb_regbank16_wr.sv
module tb_regbank16_wr;
    import regbank16_wr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_req = 1'b0;
    logic busy;
    logic [wTotal-1:0]   bank;
    logic [wEntries-1:0] vld;
    dbg_t dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regbank16_wr_if wr_if ();

    regbank16_wr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr_if.slave),
        .clr_req (clr_req),
        .busy    (busy),
        .Bank    (bank),
        .Vld     (vld),
        .dbg     (dbg)
    );

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_write(input logic [3:0] sel, input logic [15:0] data);
        int waited;
        waited = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_sel   = sel;
        wr_if.wr_data  = data;
        @(negedge clk);
        while (!wr_if.wr_ready && waited < 40) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (!wr_if.wr_ready) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout sel=%0d: wr_ready=%b after %0d cycles, required 1", sel, wr_if.wr_ready, waited);
        end
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bank !== '0) begin n_fail++; $display("FAIL reset_bank: got %h, required 0", bank); end
        n_checks++; if (vld !== 16'h0000) begin n_fail++; $display("FAIL reset_vld: got %h, required 0000", vld); end
        n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", wr_if.wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b, required IDLE", dbg.state); end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        logic [wTotal-1:0] exp_b;
        exp_b = '0;
        exp_b[63:48]   = 16'hBEEF;
        exp_b[255:240] = 16'h1234;
        do_write(4'd3, 16'hBEEF);
        @(negedge clk);
        n_checks++; if (bank[63:48] !== 16'hBEEF) begin n_fail++; $display("FAIL write_latency_e3: got %h, required BEEF", bank[63:48]); end
        @(posedge clk); #1;
        do_write(4'd15, 16'h1234);
        @(negedge clk);
        n_checks++; if (bank !== exp_b) begin n_fail++; $display("FAIL write_bank: got %h, required %h", bank, exp_b); end
        n_checks++; if (vld !== 16'h8008) begin n_fail++; $display("FAIL write_vld: got %h, required 8008", vld); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_sel   = 4'd5;
        wr_if.wr_data  = 16'hA5A5;
        @(negedge clk);
        n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, required 1", wr_if.wr_ready); end
        n_checks++; if (bank[95:80] !== 16'h0000) begin n_fail++; $display("FAIL b2b_no_bypass: got %h, required 0000", bank[95:80]); end
        @(posedge clk); #1;
        wr_if.wr_data = 16'h5A5A;
        @(negedge clk);
        n_checks++; if (bank[95:80] !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_first: got %h, required A5A5", bank[95:80]); end
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bank[95:80] !== 16'h5A5A) begin n_fail++; $display("FAIL b2b_second: got %h, required 5A5A", bank[95:80]); end
        n_checks++; if (vld !== 16'h8028) begin n_fail++; $display("FAIL b2b_vld: got %h, required 8028", vld); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear_sweep();
        logic [wTotal-1:0]   exp_b;
        logic [wEntries-1:0] exp_v;
        for (int k = 0; k < 16; k++) do_write(4'(k), 16'(k + 1));
        exp_b = '0;
        for (int k = 0; k < 16; k++) exp_b[k*16 +: 16] = 16'(k + 1);
        @(negedge clk);
        n_checks++; if (bank !== exp_b) begin n_fail++; $display("FAIL fill_bank: got %h, required %h", bank, exp_b); end
        n_checks++; if (vld !== 16'hFFFF) begin n_fail++; $display("FAIL fill_vld: got %h, required FFFF", vld); end
        @(posedge clk); #1;
        // cycle N: clear request with a competing write to entry 0
        clr_req        = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_sel   = 4'd0;
        wr_if.wr_data  = 16'hFFFF;
        @(negedge clk);
        n_checks++; if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_n: got %b, required 0", wr_if.wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy_n: got %b, required 0", busy); end
        @(posedge clk); #1;
        clr_req        = 1'b0;
        wr_if.wr_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            // cycle N+i: entries 0..i-2 already cleared
            exp_b = '0;
            exp_v = '0;
            for (int k = 0; k < 16; k++) begin
                if (k >= i - 1) begin
                    exp_b[k*16 +: 16] = 16'(k + 1);
                    exp_v[k] = 1'b1;
                end
            end
            @(negedge clk);
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy c%0d: got %b, required 1", i, busy); end
            n_checks++; if (bank !== exp_b) begin n_fail++; $display("FAIL sweep_bank c%0d: got %h, required %h", i, bank, exp_b); end
            n_checks++; if (vld !== exp_v) begin n_fail++; $display("FAIL sweep_vld c%0d: got %h, required %h", i, vld, exp_v); end
            n_checks++; if (dbg.cnt !== 4'(i - 1)) begin n_fail++; $display("FAIL sweep_cnt c%0d: got %0d, required %0d", i, dbg.cnt, i - 1); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_end_busy: got %b, required 0", busy); end
        n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_end_ready: got %b, required 1", wr_if.wr_ready); end
        n_checks++; if (bank !== '0) begin n_fail++; $display("FAIL sweep_end_bank: got %h, required 0", bank); end
        n_checks++; if (vld !== 16'h0000) begin n_fail++; $display("FAIL sweep_end_vld: got %h, required 0000", vld); end
        n_checks++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL sweep_end_state: got %b, required IDLE", dbg.state); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sweep();
        do_write(4'd10, 16'hAAAA);
        do_write(4'd12, 16'hCCCC);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (dbg.cnt !== 4'd7) begin n_fail++; $display("FAIL mid_cnt: got %0d, required 7", dbg.cnt); end
        n_checks++; if (bank[175:160] !== 16'hAAAA) begin n_fail++; $display("FAIL mid_e10: got %h, required AAAA", bank[175:160]); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bank !== '0) begin n_fail++; $display("FAIL rst_bank: got %h, required 0", bank); end
        n_checks++; if (vld !== 16'h0000) begin n_fail++; $display("FAIL rst_vld: got %h, required 0000", vld); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_sel   = 4'd9;
        wr_if.wr_data  = 16'h9999;
        @(negedge clk);
        n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b, required 1", wr_if.wr_ready); end
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bank[159:144] !== 16'h9999) begin n_fail++; $display("FAIL rel_e9: got %h, required 9999", bank[159:144]); end
        n_checks++; if (vld !== 16'h0200) begin n_fail++; $display("FAIL rel_vld: got %h, required 0200", vld); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_no_resume: got %b, required 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold_during_clear();
        logic [15:0] exp_e2;
        do_write(4'd2, 16'h1111);
        clr_req = 1'b1;
        @(posedge clk); #1;
        // CLEAR from here; clr_req held as a level for a while and must be ignored
        wr_if.wr_valid = 1'b1;
        wr_if.wr_sel   = 4'd2;
        wr_if.wr_data  = 16'h7777;
        for (int i = 1; i <= 16; i++) begin
            exp_e2 = (i <= 3) ? 16'h1111 : 16'h0000;
            @(negedge clk);
            n_checks++; if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d: got %b, required 0", i, wr_if.wr_ready); end
            n_checks++; if (bank[47:32] !== exp_e2) begin n_fail++; $display("FAIL hold_e2 c%0d: got %h, required %h", i, bank[47:32], exp_e2); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy c%0d: got %b, required 1", i, busy); end
            @(posedge clk); #1;
            if (i == 4) clr_req = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready: got %b, required 1", wr_if.wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bank !== {208'h0, 16'h7777, 32'h0}) begin n_fail++; $display("FAIL hold_done_bank: got %h, required e2=7777 only", bank); end
        n_checks++; if (vld !== 16'h0004) begin n_fail++; $display("FAIL hold_done_vld: got %h, required 0004", vld); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_sel   = '0;
        wr_if.wr_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_hold_during_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
